// File: rtl/memlat_model.sv
// memlat_model: unified instruction/data memory with a zero-latency data port and a
// restartable fixed-latency fetch FSM. Define MEMLAT_OOR_EN to add out-of-range checking.
module memlat_model #(
  parameter int N    = 64,
  parameter int L    = 128,
  parameter int ILAT = 20
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic [1:0]   i_memwrite,
  input  logic [N-1:0] i_dataadr,
  input  logic [N-1:0] i_writedata,
  output logic [N-1:0] o_readdata,
  input  logic [31:0]  i_instradr,
  input  logic         i_instrreq,
  output logic [31:0]  o_instr,
  output logic         o_ival,
  output logic         o_istall,
  output logic         o_adrerr,
  input  logic [7:0]   i_checka,
  output logic [31:0]  o_check
);
  localparam int AW = $clog2(L);
  localparam logic [7:0] CNT_INIT = 8'(ILAT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Big-endian word pair: lo=0 selects the upper word.
  function automatic logic [31:0] sel_word(input logic [N-1:0] entry, input logic lo);
    sel_word = lo ? entry[31:0] : entry[63:32];
  endfunction

  logic [N-1:0] r_mem [0:L-1];
  state_t       r_state, w_state_nxt;
  logic [7:0]   r_cnt, w_cnt_nxt;
  logic [31:0]  r_fadr, w_fadr_nxt;
  logic [31:0]  r_instr;
  logic         r_ival;

  logic [AW-1:0] w_didx;
  logic [N-1:0]  w_dentry, w_wentry;
  logic [31:0]   w_dword, w_fword;
  logic [5:0]    w_bsh;
  logic          w_we;
  logic          w_door, w_foor, w_ioor;

  assign w_didx   = i_dataadr[AW+2:3];
  assign w_dentry = r_mem[w_didx];
  assign w_dword  = sel_word(w_dentry, i_dataadr[2]);
  assign w_bsh    = {~i_dataadr[2:0], 3'b000};

`ifdef MEMLAT_OOR_EN
  logic r_adrerr;
  assign w_door = |i_dataadr[N-1:AW+3];
  assign w_foor = |r_fadr[31:AW+3];
  assign w_ioor = |i_instradr[31:AW+3];

  // Sticky out-of-range flag.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_adrerr <= 1'b0;
    end else if (w_door || (i_instrreq && w_ioor)) begin
      r_adrerr <= 1'b1;
    end
  end
  assign o_adrerr = r_adrerr;
`else
  logic w_unused_adr;
  assign w_unused_adr = ^i_dataadr[N-1:AW+3];
  assign w_door   = 1'b0;
  assign w_foor   = 1'b0;
  assign w_ioor   = 1'b0;
  assign o_adrerr = 1'b0;
`endif

  // Merge store data into the addressed entry.
  always_comb begin
    w_wentry = w_dentry;
    w_we     = 1'b0;
    case (i_memwrite)
      2'd1: begin
        w_we = ~w_door;
        if (i_dataadr[2]) begin
          w_wentry[31:0] = i_writedata[31:0];
        end else begin
          w_wentry[63:32] = i_writedata[31:0];
        end
      end
      2'd2: begin
        w_we = ~w_door;
        w_wentry[w_bsh +: 8] = i_writedata[7:0];
      end
      2'd3: begin
        w_we     = ~w_door;
        w_wentry = i_writedata;
      end
      default: begin
        w_we = 1'b0;
      end
    endcase
  end

  // RAM array, not reset.
  always_ff @(posedge i_clk) begin
    if (w_we) begin
      r_mem[w_didx] <= w_wentry;
    end
  end

  assign o_readdata = w_door ? {N{1'b0}} : {{(N-32){1'b0}}, w_dword};
  assign o_check    = sel_word(r_mem[i_checka[AW:1]], i_checka[0]);
  assign w_fword    = w_foor ? 32'd0 : sel_word(r_mem[r_fadr[AW+2:3]], r_fadr[2]);

  // Fetch FSM next-state: a changed address in WAIT restarts the countdown.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_fadr_nxt  = r_fadr;
    case (r_state)
      S_IDLE: begin
        if (i_instrreq) begin
          w_fadr_nxt  = i_instradr;
          w_cnt_nxt   = CNT_INIT;
          w_state_nxt = (ILAT == 1) ? S_RESP : S_WAIT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (!i_instrreq) begin
          w_state_nxt = S_IDLE;
        end else if (i_instradr != r_fadr) begin
          w_fadr_nxt = i_instradr;
          w_cnt_nxt  = CNT_INIT;
        end else if (r_cnt == 8'd0) begin
          w_state_nxt = S_RESP;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Fetch FSM state and response registers.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      r_fadr  <= 32'd0;
      r_instr <= 32'd0;
      r_ival  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_fadr  <= w_fadr_nxt;
      r_ival  <= (r_state == S_RESP);
      if (r_state == S_RESP) begin
        r_instr <= w_fword;
      end
    end
  end

  assign o_instr  = r_instr;
  assign o_ival   = r_ival;
  assign o_istall = i_instrreq & ~r_ival;

endmodule
